fb_read_arbiter: RTL



---
 rtl/fb_read_arbiter.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/fb_read_arbiter.sv
// Shares one framebuffer read port between VGA scanout (high priority) and a frame-dump sequencer.
// Define FB_ARB_STATS_EN to add the vga_conflicts / dump_frames statistics ports.

module fb_read_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int PIX_W      = 3,
  parameter int PX_WIDTH   = 160,
  parameter int PX_HEIGHT  = 120,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic [PIX_W-1:0]  vga_rdata,
  output logic              vga_rvalid,
  input  logic              dump_start,
  output logic              dump_busy,
  output logic [PIX_W-1:0]  dump_pix,
  output logic              dump_valid,
  output logic              dump_eol,
  output logic              dump_done,
  output logic [ADDR_W-1:0] mem_addr,
`ifdef FB_ARB_STATS_EN
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [15:0]       vga_conflicts,
  output logic [15:0]       dump_frames
`else
  input  logic [PIX_W-1:0]  mem_rdata
`endif
);

  localparam int N  = PX_WIDTH * PX_HEIGHT;
  localparam int CW = (PX_WIDTH > 1) ? $clog2(PX_WIDTH) : 1;
  localparam int RW = (PX_HEIGHT > 1) ? $clog2(PX_HEIGHT) : 1;
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(N - 1);
  localparam logic [CW-1:0]     LAST_COL   = CW'(PX_WIDTH - 1);
  localparam logic [RW-1:0]     LAST_ROW   = RW'(PX_HEIGHT - 1);
  localparam logic [SW-1:0]     STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_VGA, OWN_DUMP} owner_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  owner_t            tag_own_q [0:MEM_LAT];
  owner_t            tag_own_d [0:MEM_LAT];
  logic              tag_eol_q [0:MEM_LAT];
  logic              tag_eol_d [0:MEM_LAT];
  logic              vga_rvalid_q, vga_rvalid_d;
  logic [PIX_W-1:0]  vga_rdata_q, vga_rdata_d;
  logic              dump_valid_q, dump_valid_d;
  logic [PIX_W-1:0]  dump_pix_q, dump_pix_d;
  logic              dump_eol_q, dump_eol_d;

  logic dump_req, starved, dump_win, vga_win, dump_inflight;

  assign dump_req = (state_q == S_SCAN);
  assign starved  = (STARVE_MAX != 0) && (starve_q == STARVE_LIM);
  assign dump_win = dump_req && (!vga_req || starved);
  assign vga_win  = vga_req && !dump_win;
  // Gated by reset so the port reads as idle while clr is low.
  assign vga_gnt  = vga_win && clr;

  always_comb begin
    dump_inflight = 1'b0;
    for (int k = 0; k <= MEM_LAT; k++) begin
      if (tag_own_q[k] == OWN_DUMP) dump_inflight = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    col_d        = col_q;
    row_d        = row_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    mem_addr_d   = mem_addr_q;
    tag_own_d    = tag_own_q;
    tag_eol_d    = tag_eol_q;
    vga_rvalid_d = (tag_own_q[MEM_LAT] == OWN_VGA);
    vga_rdata_d  = vga_rdata_q;
    dump_valid_d = (tag_own_q[MEM_LAT] == OWN_DUMP);
    dump_pix_d   = dump_pix_q;
    dump_eol_d   = 1'b0;

    // Tag stage k lines up with mem_rdata when k == MEM_LAT.
    for (int k = 1; k <= MEM_LAT; k++) begin
      tag_own_d[k] = tag_own_q[k-1];
      tag_eol_d[k] = tag_eol_q[k-1];
    end
    tag_own_d[0] = OWN_NONE;
    tag_eol_d[0] = 1'b0;
    if (vga_win) begin
      mem_addr_d   = vga_addr;
      tag_own_d[0] = OWN_VGA;
    end else if (dump_win) begin
      mem_addr_d   = index_q;
      tag_own_d[0] = OWN_DUMP;
      tag_eol_d[0] = (col_q == LAST_COL);
    end

    if (tag_own_q[MEM_LAT] == OWN_VGA) vga_rdata_d = mem_rdata;
    if (tag_own_q[MEM_LAT] == OWN_DUMP) begin
      dump_pix_d = mem_rdata;
      dump_eol_d = tag_eol_q[MEM_LAT];
    end

    if (!dump_req || dump_win) starve_d = '0;
    else if (starve_q != STARVE_LIM) starve_d = starve_q + SW'(1);
    else starve_d = starve_q;

    case (state_q)
      S_IDLE: begin
        if (dump_start) begin
          state_d = S_SCAN;
          index_d = '0;
          col_d   = '0;
          row_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_SCAN: begin
        if (dump_win) begin
          index_d = index_q + ADDR_W'(1);
          if (col_q == LAST_COL) begin
            col_d = '0;
            row_d = (row_q == LAST_ROW) ? '0 : row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
          if (index_q == LAST_IDX) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!dump_inflight) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q      <= S_IDLE;
      index_q      <= '0;
      col_q        <= '0;
      row_q        <= '0;
      starve_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mem_addr_q   <= '0;
      for (int k = 0; k <= MEM_LAT; k++) begin
        tag_own_q[k] <= OWN_NONE;
        tag_eol_q[k] <= 1'b0;
      end
      vga_rvalid_q <= 1'b0;
      vga_rdata_q  <= '0;
      dump_valid_q <= 1'b0;
      dump_pix_q   <= '0;
      dump_eol_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      col_q        <= col_d;
      row_q        <= row_d;
      starve_q     <= starve_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      mem_addr_q   <= mem_addr_d;
      tag_own_q    <= tag_own_d;
      tag_eol_q    <= tag_eol_d;
      vga_rvalid_q <= vga_rvalid_d;
      vga_rdata_q  <= vga_rdata_d;
      dump_valid_q <= dump_valid_d;
      dump_pix_q   <= dump_pix_d;
      dump_eol_q   <= dump_eol_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign vga_rvalid = vga_rvalid_q;
  assign vga_rdata  = vga_rdata_q;
  assign dump_valid = dump_valid_q;
  assign dump_pix   = dump_pix_q;
  assign dump_eol   = dump_eol_q;
  assign dump_busy  = busy_q;
  assign dump_done  = done_q;

`ifdef FB_ARB_STATS_EN
  logic [15:0] conflicts_q, conflicts_d;
  logic [15:0] frames_q, frames_d;

  // A dump win while VGA is requesting can only be a starvation override.
  always_comb begin
    conflicts_d = conflicts_q;
    frames_d    = frames_q;
    if (vga_req && dump_win) conflicts_d = conflicts_q + 16'd1;
    if (done_d) frames_d = frames_q + 16'd1;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      conflicts_q <= '0;
      frames_q    <= '0;
    end else begin
      conflicts_q <= conflicts_d;
      frames_q    <= frames_d;
    end
  end

  assign vga_conflicts = conflicts_q;
  assign dump_frames   = frames_q;
`endif

endmodule
